// File: rtl/aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// aes_key_sched_ctrl
//   AES-128 key expansion controller. Accepts a 128-bit cipher key, expands
//   it one 32-bit word per cycle (w[4]..w[43]) using a shared external
//   combinational S-box, keeps all 44 words, and serves the 11 round keys
//   through a registered indexed read port.
//
// Ports
//   clk          clock, all state updates on posedge
//   rst_n        asynchronous active-low reset
//   key_valid    new cipher key offered
//   key_ready    controller can accept a key (low only while expanding)
//   key          cipher key, key[127:96] = w[0] ... key[31:0] = w[3]
//   sbox_in      word presented to the external 4-lane S-box
//   sbox_out     SubWord(sbox_in), valid in the same cycle
//   busy         expansion in progress
//   keys_rdy     all 11 round keys valid for the current key
//   rk_rd_en     round-key read request
//   rk_rd_idx    round index 0..10
//   rk_rd_data   {w[4r], w[4r+1], w[4r+2], w[4r+3]}, one cycle after request
//   rk_rd_valid  one-cycle pulse, rk_rd_data valid
//   rk_rd_err    one-cycle pulse, request rejected (data left unchanged)
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no key loaded since reset, waiting for key_valid
// EXPAND | writing w[i], i = 4..43, one word per cycle
// DONE   | all round keys valid, serving reads, a new key restarts expansion
// ---------------------------------------------------------------------------
module aes_key_sched_ctrl (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   output logic [31:0]  sbox_in,
   input  logic [31:0]  sbox_out,
   output logic         busy,
   output logic         keys_rdy,
   input  logic         rk_rd_en,
   input  logic [3:0]   rk_rd_idx,
   output logic [127:0] rk_rd_data,
   output logic         rk_rd_valid,
   output logic         rk_rd_err
);

   localparam int NB = 4;
   localparam int NK = 4;
   localparam int NR = 10;
   localparam int NW = NB * (NR + 1);

   localparam logic [3:0] LAST_RK = 4'(NR);
   localparam logic [5:0] LAST_W  = 6'(NW - 1);
   localparam logic [5:0] FIRST_X = 6'(NK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] w [NW];
   logic [5:0]  i;
   logic [7:0]  rcon;

   logic        accept;
   logic [5:0]  i_m1;
   logic [5:0]  i_m4;
   logic [31:0] w_prev;
   logic [31:0] w_back;
   logic [31:0] w_mix;
   logic [31:0] w_new;
   logic        rd_ok;
   logic [5:0]  rd_base;
   logic [127:0] rd_word;

   function automatic logic [31:0] rot_word(input logic [31:0] x);
      return {x[23:0], x[31:24]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign accept = key_valid & key_ready;

   // Only meaningful in EXPAND, where i is 4..43 so both indices stay in range.
   always_comb begin
      i_m1   = i - 6'd1;
      i_m4   = i - 6'd4;
      w_prev = w[i_m1];
      w_back = w[i_m4];
      w_mix  = (i[1:0] == 2'b00) ? (sbox_out ^ {rcon, 24'h0}) : w_prev;
      w_new  = w_back ^ w_mix;
   end

   // Out-of-range indices fall back to word 0 so the mux never addresses
   // past the store; the request is rejected anyway.
   always_comb begin
      rd_ok   = (rk_rd_idx <= LAST_RK);
      rd_base = rd_ok ? {rk_rd_idx, 2'b00} : 6'd0;
      rd_word = {w[rd_base], w[rd_base + 6'd1], w[rd_base + 6'd2], w[rd_base + 6'd3]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         i           <= 6'd0;
         rcon        <= 8'h01;
         key_ready   <= 1'b1;
         busy        <= 1'b0;
         keys_rdy    <= 1'b0;
         sbox_in     <= 32'h0;
         rk_rd_data  <= 128'h0;
         rk_rd_valid <= 1'b0;
         rk_rd_err   <= 1'b0;
         for (int k = 0; k < NW; k++) begin
            w[k] <= 32'h0;
         end
      end else begin
         rk_rd_valid <= 1'b0;
         rk_rd_err   <= 1'b0;

         // A key accepted this cycle invalidates the store immediately, so a
         // read in the same cycle is rejected rather than served stale data.
         if (rk_rd_en) begin
            if (!accept && keys_rdy && rd_ok) begin
               rk_rd_data  <= rd_word;
               rk_rd_valid <= 1'b1;
            end else begin
               rk_rd_err   <= 1'b1;
            end
         end

         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  for (int k = 0; k < NK; k++) begin
                     w[k] <= key[127 - 32*k -: 32];
                  end
                  i         <= FIRST_X;
                  rcon      <= 8'h01;
                  keys_rdy  <= 1'b0;
                  busy      <= 1'b1;
                  key_ready <= 1'b0;
                  // Pre-load RotWord(w[3]) so the S-box result is ready for w[4].
                  sbox_in   <= rot_word(key[31:0]);
                  state     <= EXPAND;
               end
            end

            EXPAND: begin
               w[i]    <= w_new;
               sbox_in <= rot_word(w_new);
               if (i[1:0] == 2'b00) begin
                  rcon <= xtime(rcon);
               end
               if (i == LAST_W) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  keys_rdy  <= 1'b1;
                  key_ready <= 1'b1;
               end else begin
                  i <= i + 6'd1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_key_sched_ctrl
//   Directed bench for aes_key_sched_ctrl using FIPS-197 expansion vectors.
//   The external S-box is modelled from GF(2^8) inversion plus the affine map.
// ---------------------------------------------------------------------------
module tb_aes_key_sched_ctrl;

   logic         clk;
   logic         rst_n;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key;
   logic [31:0]  sbox_in;
   logic [31:0]  sbox_out;
   logic         busy;
   logic         keys_rdy;
   logic         rk_rd_en;
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;
   logic         rk_rd_valid;
   logic         rk_rd_err;

   int n_chk;
   int n_fail;
   logic [127:0] last_data;

   logic [7:0] sbox_tbl [256];

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_Z = 128'h0;
   localparam logic [127:0] KEY_X = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   logic [127:0] rk_a [11] = '{
      128'h2b7e151628aed2a6abf7158809cf4f3c,
      128'ha0fafe1788542cb123a339392a6c7605,
      128'hf2c295f27a96b9435935807a7359f67f,
      128'h3d80477d4716fe3e1e237e446d7a883b,
      128'hef44a541a8525b7fb671253bdb0bad00,
      128'hd4d1c6f87c839d87caf2b8bc11f915bc,
      128'h6d88a37a110b3efddbf98641ca0093fd,
      128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
      128'head27321b58dbad2312bf5607f8d292f,
      128'hac7766f319fadc2128d12941575c006e,
      128'hd014f9a8c9ee2589e13f0cc8b6630ca6
   };

   aes_key_sched_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_valid   (key_valid),
      .key_ready   (key_ready),
      .key         (key),
      .sbox_in     (sbox_in),
      .sbox_out    (sbox_out),
      .busy        (busy),
      .keys_rdy    (keys_rdy),
      .rk_rd_en    (rk_rd_en),
      .rk_rd_idx   (rk_rd_idx),
      .rk_rd_data  (rk_rd_data),
      .rk_rd_valid (rk_rd_valid),
      .rk_rd_err   (rk_rd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign sbox_out = {sbox_tbl[sbox_in[31:24]], sbox_tbl[sbox_in[23:16]],
                      sbox_tbl[sbox_in[15:8]],  sbox_tbl[sbox_in[7:0]]};

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h0;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int n = 0; n < 8; n++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h0;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_tbl[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                       ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_key(input logic [127:0] k);
      key       = k;
      key_valid = 1'b1;
      tick();
      key_valid = 1'b0;
   endtask

   // Called in cycle T+1. Walks T+1..T+40 expecting expansion in progress,
   // then checks the handshake outputs in T+41. key_valid is dropped before
   // the DONE transition so a held key is never re-accepted.
   task automatic expect_expand(input string tag, input bit rd_busy);
      bit ok       = 1'b1;
      bit rd_seen  = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         if (busy !== 1'b1 || keys_rdy !== 1'b0 || key_ready !== 1'b0) ok = 1'b0;
         if (j == 40) key_valid = 1'b0;
         if (rd_busy && j == 5) begin
            rk_rd_en  = 1'b1;
            rk_rd_idx = 4'd2;
         end
         tick();
         if (rd_busy && j == 5) begin
            rk_rd_en = 1'b0;
            rd_seen  = (rk_rd_err === 1'b1) && (rk_rd_valid === 1'b0)
                       && (rk_rd_data === last_data);
         end
      end
      chk({tag, "_expanding"}, {127'h0, ok}, 128'h1);
      if (rd_busy) chk({tag, "_rd_busy_err"}, {127'h0, rd_seen}, 128'h1);
      chk({tag, "_keys_rdy"},  {127'h0, keys_rdy},  128'h1);
      chk({tag, "_busy_low"},  {127'h0, busy},      128'h0);
      chk({tag, "_key_ready"}, {127'h0, key_ready}, 128'h1);
   endtask

   task automatic rd(input string tag, input logic [3:0] idx, input bit exp_ok,
                     input logic [127:0] exp_data);
      rk_rd_en  = 1'b1;
      rk_rd_idx = idx;
      tick();
      rk_rd_en  = 1'b0;
      chk({tag, "_valid"}, {127'h0, rk_rd_valid}, {127'h0, exp_ok});
      chk({tag, "_err"},   {127'h0, rk_rd_err},   {127'h0, ~exp_ok});
      if (exp_ok) last_data = exp_data;
      chk({tag, "_data"},  rk_rd_data, last_data);
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      last_data = 128'h0;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key       = 128'h0;
      rk_rd_en  = 1'b0;
      rk_rd_idx = 4'd0;
      build_sbox();

      repeat (3) tick();
      chk("rst_key_ready", {127'h0, key_ready},   128'h1);
      chk("rst_busy",      {127'h0, busy},        128'h0);
      chk("rst_keys_rdy",  {127'h0, keys_rdy},    128'h0);
      chk("rst_rd_valid",  {127'h0, rk_rd_valid}, 128'h0);
      chk("rst_rd_err",    {127'h0, rk_rd_err},   128'h0);
      chk("rst_rd_data",   rk_rd_data,            128'h0);
      chk("rst_sbox_in",   {96'h0, sbox_in},      128'h0);
      chk("sbox_model_0",  {120'h0, sbox_tbl[0]}, 128'h63);
      rst_n = 1'b1;
      tick();

      // Read before any key is loaded.
      rd("rd_idle", 4'd0, 1'b0, 128'h0);

      // FIPS-197 A.1 key: exact latency, read while busy, all 11 round keys.
      load_key(KEY_A);
      expect_expand("a", 1'b1);
      for (int r = 0; r < 11; r++) begin
         rd($sformatf("a_rk%0d", r), 4'(r), 1'b1, rk_a[r]);
      end

      // Out-of-range indices.
      rd("rd_idx11", 4'd11, 1'b0, 128'h0);
      rd("rd_idx15", 4'd15, 1'b0, 128'h0);
      rd("rd_after_err", 4'd3, 1'b1, rk_a[3]);

      // New key accepted in DONE in the same cycle as a read: read rejected.
      rk_rd_en  = 1'b1;
      rk_rd_idx = 4'd4;
      load_key(KEY_Z);
      rk_rd_en  = 1'b0;
      chk("acc_rd_err",   {127'h0, rk_rd_err},   128'h1);
      chk("acc_rd_valid", {127'h0, rk_rd_valid}, 128'h0);
      chk("acc_rd_data",  rk_rd_data,            last_data);
      expect_expand("z", 1'b0);
      rd("z_rk0",  4'd0,  1'b1, KEY_Z);
      rd("z_rk1",  4'd1,  1'b1, Z_RK1);
      rd("z_rk10", 4'd10, 1'b1, Z_RK10);

      // Different key held on key_valid during expansion is ignored.
      key       = KEY_A;
      key_valid = 1'b1;
      tick();
      key       = KEY_X;
      expect_expand("hold", 1'b0);
      rd("hold_rk1",  4'd1,  1'b1, rk_a[1]);
      rd("hold_rk10", 4'd10, 1'b1, rk_a[10]);

      // Reset mid-expansion at T+20, then a clean reload.
      load_key(KEY_Z);
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      last_data = 128'h0;
      chk("abort_busy",      {127'h0, busy},      128'h0);
      chk("abort_keys_rdy",  {127'h0, keys_rdy},  128'h0);
      chk("abort_key_ready", {127'h0, key_ready}, 128'h1);
      chk("abort_rd_data",   rk_rd_data,          128'h0);
      tick();
      rst_n = 1'b1;
      tick();
      rd("abort_rd", 4'd1, 1'b0, 128'h0);
      load_key(KEY_A);
      expect_expand("reload", 1'b0);
      rd("reload_rk10", 4'd10, 1'b1, rk_a[10]);
      rd("reload_rk0",  4'd0,  1'b1, rk_a[0]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
